// File: rtl/vmem_pkg.sv
// Shared constants and types for the vmem rectangle-fill engine.
// Register offsets, control bits, screen defaults and FSM encoding.
package vmem_pkg;

   localparam int SCREEN_W_DEF = 240;
   localparam int SCREEN_H_DEF = 240;

   localparam logic [3:0] REG_CTRL   = 4'h0;
   localparam logic [3:0] REG_ORIGIN = 4'h4;
   localparam logic [3:0] REG_SIZE   = 4'h8;
   localparam logic [3:0] REG_COLOR  = 4'hC;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_e;

   // Clipped extent along one axis: 0 when the origin is off-screen.
   function automatic logic [8:0] clip_len(
      input logic [7:0] org,
      input logic [7:0] len,
      input logic [8:0] lim
   );
      logic [8:0] room;
      room = lim - {1'b0, org};
      if ({1'b0, org} >= lim) return 9'd0;
      if ({1'b0, len} < room) return {1'b0, len};
      return room;
   endfunction

endpackage

// File: rtl/vmem_fill_arb_cursor.sv
// 2-D raster cursor: load origin/limits, advance x first, wrap to x0.
// last flags the final pixel of the rectangle.
module fill_cursor (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       adv,
   input  logic [8:0] x0,
   input  logic [8:0] y0,
   input  logic [8:0] x_last,
   input  logic [8:0] y_last,
   output logic [8:0] cx,
   output logic [8:0] cy,
   output logic       last
);

   logic [8:0] x0_q;
   logic [8:0] xl_q;
   logic [8:0] yl_q;
   logic [8:0] cx_q;
   logic [8:0] cy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         x0_q <= '0;
         xl_q <= '0;
         yl_q <= '0;
         cx_q <= '0;
         cy_q <= '0;
      end else if (load) begin
         x0_q <= x0;
         xl_q <= x_last;
         yl_q <= y_last;
         cx_q <= x0;
         cy_q <= y0;
      end else if (adv) begin
         if (cx_q == xl_q) begin
            cx_q <= x0_q;
            cy_q <= cy_q + 9'd1;
         end else begin
            cx_q <= cx_q + 9'd1;
         end
      end
   end

   assign cx   = cx_q;
   assign cy   = cy_q;
   assign last = (cx_q == xl_q) && (cy_q == yl_q);

endmodule

// File: rtl/vmem_fill_arb.sv
// Rectangle-fill engine sharing the vmem write port with CPU stores.
// CPU stores always win; the fill cursor stalls for that cycle.
module vmem_fill_arb
   import vmem_pkg::*;
#(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        reg_we_i,
   input  logic [3:0]  reg_addr_i,
   input  logic [31:0] reg_wdata_i,
   output logic [31:0] reg_rdata_o,
   input  logic        pix_we_i,
   input  logic [15:0] pix_addr_i,
   input  logic [2:0]  pix_wdata_i,
   output logic        vmem_we_o,
   output logic [15:0] vmem_addr_o,
   output logic [2:0]  vmem_wdata_o,
   output logic        busy_o
);

   fill_state_e state_q;
   fill_state_e state_d;

   logic [15:0] origin_q;
   logic [15:0] size_q;
   logic [2:0]  color_q;
   logic [2:0]  color_w;
   logic        done_q;

   logic        ctrl_wr;
   logic        start_req;
   logic        abort_req;
   logic [8:0]  ew;
   logic [8:0]  eh;
   logic [8:0]  x0;
   logic [8:0]  y0;
   logic [8:0]  x_last;
   logic [8:0]  y_last;
   logic        zero_sz;

   logic        load;
   logic        fill_req;
   logic        done_set;
   logic        done_clr;
   logic        busy;

   logic [8:0]  cx;
   logic [8:0]  cy;
   logic        last;
   logic [31:0] rd_d;
   logic        unused;

   assign ctrl_wr   = reg_we_i && (reg_addr_i == REG_CTRL);
   assign start_req = ctrl_wr && reg_wdata_i[CTRL_START];
   assign abort_req = ctrl_wr && reg_wdata_i[CTRL_ABORT];

   assign x0      = {1'b0, origin_q[7:0]};
   assign y0      = {1'b0, origin_q[15:8]};
   assign ew      = clip_len(origin_q[7:0], size_q[7:0], 9'(SCREEN_W));
   assign eh      = clip_len(origin_q[15:8], size_q[15:8], 9'(SCREEN_H));
   assign x_last  = x0 + ew - 9'd1;
   assign y_last  = y0 + eh - 9'd1;
   assign zero_sz = (ew == 9'd0) || (eh == 9'd0);

   assign busy   = (state_q == ST_FILL);
   assign busy_o = busy;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Abort suppresses the fill request of its own cycle.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      fill_req = 1'b0;
      done_set = 1'b0;
      done_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_req && !abort_req) begin
               if (zero_sz) begin
                  done_set = 1'b1;
               end else begin
                  load     = 1'b1;
                  done_clr = 1'b1;
                  state_d  = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (abort_req) begin
               state_d = ST_IDLE;
            end else if (!pix_we_i) begin
               fill_req = 1'b1;
               if (last) begin
                  done_set = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   fill_cursor u_cursor (
      .clk    (clk_i),
      .rst    (rst_i),
      .load   (load),
      .adv    (fill_req),
      .x0     (x0),
      .y0     (y0),
      .x_last (x_last),
      .y_last (y_last),
      .cx     (cx),
      .cy     (cy),
      .last   (last)
   );

   always_comb begin
      rd_d = '0;
      unique case (1'b1)
         (reg_addr_i == REG_CTRL):   rd_d = {30'b0, done_q, busy};
         (reg_addr_i == REG_ORIGIN): rd_d = {16'b0, origin_q};
         (reg_addr_i == REG_SIZE):   rd_d = {16'b0, size_q};
         (reg_addr_i == REG_COLOR):  rd_d = {29'b0, color_q};
         default:                    rd_d = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         origin_q <= '0;
         size_q   <= '0;
         color_q  <= '0;
      end else if (reg_we_i) begin
         unique case (1'b1)
            (reg_addr_i == REG_ORIGIN): origin_q <= reg_wdata_i[15:0];
            (reg_addr_i == REG_SIZE):   size_q   <= reg_wdata_i[15:0];
            (reg_addr_i == REG_COLOR):  color_q  <= reg_wdata_i[2:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         color_w <= '0;
         done_q  <= 1'b0;
      end else begin
         if (load) color_w <= color_q;
         if (done_set)      done_q <= 1'b1;
         else if (done_clr) done_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vmem_we_o    <= 1'b0;
         vmem_addr_o  <= '0;
         vmem_wdata_o <= '0;
         reg_rdata_o  <= '0;
      end else begin
         vmem_we_o   <= pix_we_i || fill_req;
         reg_rdata_o <= rd_d;
         if (pix_we_i) begin
            vmem_addr_o  <= pix_addr_i;
            vmem_wdata_o <= pix_wdata_i;
         end else if (fill_req) begin
            vmem_addr_o  <= {cy[7:0], cx[7:0]};
            vmem_wdata_o <= color_w;
         end
      end
   end

   assign unused = ^{reg_wdata_i[31:16], cx[8], cy[8]};

endmodule

// File: tb/tb_vmem_fill_arb.sv
// Scoreboard bench for vmem_fill_arb: pixel-list reference model,
// directed test-plan cases and a randomized arbitration phase.
module tb_vmem_fill_arb;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        reg_we_i;
   logic [3:0]  reg_addr_i;
   logic [31:0] reg_wdata_i;
   logic [31:0] reg_rdata_o;
   logic        pix_we_i;
   logic [15:0] pix_addr_i;
   logic [2:0]  pix_wdata_i;
   logic        vmem_we_o;
   logic [15:0] vmem_addr_o;
   logic [2:0]  vmem_wdata_o;
   logic        busy_o;

   always #5 clk = ~clk;

   vmem_fill_arb dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .reg_we_i     (reg_we_i),
      .reg_addr_i   (reg_addr_i),
      .reg_wdata_i  (reg_wdata_i),
      .reg_rdata_o  (reg_rdata_o),
      .pix_we_i     (pix_we_i),
      .pix_addr_i   (pix_addr_i),
      .pix_wdata_i  (pix_wdata_i),
      .vmem_we_o    (vmem_we_o),
      .vmem_addr_o  (vmem_addr_o),
      .vmem_wdata_o (vmem_wdata_o),
      .busy_o       (busy_o)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [2:0]  d;
   } wr_t;

   wr_t exp_q[$];
   wr_t pend[$];
   wr_t obs[$];

   int errors = 0;
   int checks = 0;
   int busy_cnt = 0;
   bit mon_en = 0;

   logic [15:0] m_origin;
   logic [15:0] m_size;
   logic [2:0]  m_color;
   bit          m_busy;
   bit          m_done;
   bit          m_we;
   logic [31:0] m_rdata;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: a fill is a list of pixels drained one per free cycle.
   task automatic model_step();
      int x0, y0, w, h, ew, eh;
      bit st, ab;
      if (rst_i) begin
         m_origin = '0; m_size = '0; m_color = '0;
         m_busy = 0; m_done = 0; m_we = 0; m_rdata = '0;
         pend.delete();
         return;
      end
      m_we = 0;
      case (reg_addr_i)
         4'h0: m_rdata = {30'b0, m_done, m_busy};
         4'h4: m_rdata = {16'b0, m_origin};
         4'h8: m_rdata = {16'b0, m_size};
         4'hC: m_rdata = {29'b0, m_color};
         default: m_rdata = '0;
      endcase
      st = reg_we_i && reg_addr_i == 4'h0 && reg_wdata_i[0];
      ab = reg_we_i && reg_addr_i == 4'h0 && reg_wdata_i[1];
      if (pix_we_i) begin
         exp_q.push_back(wr_t'({pix_addr_i, pix_wdata_i}));
         m_we = 1;
      end
      if (m_busy) begin
         if (ab) begin
            m_busy = 0;
            pend.delete();
         end else if (!pix_we_i) begin
            exp_q.push_back(pend.pop_front());
            m_we = 1;
            if (pend.size() == 0) begin
               m_busy = 0;
               m_done = 1;
            end
         end
      end else if (st && !ab) begin
         x0 = int'(m_origin[7:0]);  y0 = int'(m_origin[15:8]);
         w  = int'(m_size[7:0]);    h  = int'(m_size[15:8]);
         ew = (x0 >= 240) ? 0 : ((w < 240 - x0) ? w : 240 - x0);
         eh = (y0 >= 240) ? 0 : ((h < 240 - y0) ? h : 240 - y0);
         if (ew == 0 || eh == 0) begin
            m_done = 1;
         end else begin
            for (int y = y0; y < y0 + eh; y++)
               for (int x = x0; x < x0 + ew; x++)
                  pend.push_back(wr_t'({8'(y), 8'(x), m_color}));
            m_busy = 1;
            m_done = 0;
         end
      end
      if (reg_we_i) begin
         case (reg_addr_i)
            4'h4: m_origin = reg_wdata_i[15:0];
            4'h8: m_size   = reg_wdata_i[15:0];
            4'hC: m_color  = reg_wdata_i[2:0];
            default: ;
         endcase
      end
   endtask

   task automatic monitor_step();
      wr_t e;
      chk("vmem_we", 32'(vmem_we_o), 32'(m_we));
      if (vmem_we_o) begin
         obs.push_back(wr_t'({vmem_addr_o, vmem_wdata_o}));
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: got addr %h data %0d want none",
                     vmem_addr_o, vmem_wdata_o);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", 32'(vmem_addr_o), 32'(e.a));
            chk("write_data", 32'(vmem_wdata_o), 32'(e.d));
         end
      end
      if (busy_o) busy_cnt++;
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("rdata", reg_rdata_o, m_rdata);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
      #1;
      if (mon_en) monitor_step();
   end

   task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      reg_we_i = 1; reg_addr_i = a; reg_wdata_i = d;
      @(negedge clk);
      reg_we_i = 0;
   endtask

   task automatic read_chk(input string name, input logic [3:0] a,
                           input logic [31:0] exp);
      @(negedge clk);
      reg_addr_i = a;
      @(negedge clk);
      chk(name, reg_rdata_o, exp);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy_o && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(busy_o), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_obs(input int cnt, input int limit);
      int n = 0;
      while (obs.size() < cnt && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("obs_wait", obs.size(), cnt);
   endtask

   logic [15:0] basic_a[6] = '{16'h0302, 16'h0303, 16'h0304,
                               16'h0402, 16'h0403, 16'h0404};
   logic [15:0] arb_a[5]   = '{16'h0A10, 16'h0A11, 16'h1234,
                               16'h0A12, 16'h0A13};
   logic [2:0]  arb_d[5]   = '{3'd3, 3'd3, 3'd2, 3'd3, 3'd3};

   initial begin
      rst_i = 1; reg_we_i = 0; reg_addr_i = '0; reg_wdata_i = '0;
      pix_we_i = 0; pix_addr_i = '0; pix_wdata_i = '0;
      repeat (3) @(negedge clk);
      mon_en = 1;
      @(negedge clk);
      rst_i = 0;
      chk("rst_we", 32'(vmem_we_o), 32'd0);
      chk("rst_addr", 32'(vmem_addr_o), 32'd0);
      chk("rst_wdata", 32'(vmem_wdata_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_rdata", reg_rdata_o, 32'd0);

      // basic fill
      obs.delete(); busy_cnt = 0;
      reg_wr(4'h4, 32'h0302); reg_wr(4'h8, 32'h0203);
      reg_wr(4'hC, 32'd5);    reg_wr(4'h0, 32'd1);
      wait_idle(100);
      chk("basic_count", obs.size(), 6);
      for (int i = 0; i < 6 && i < obs.size(); i++) begin
         chk("basic_addr", 32'(obs[i].a), 32'(basic_a[i]));
         chk("basic_data", 32'(obs[i].d), 32'd5);
      end
      chk("basic_busy_cycles", busy_cnt, 6);
      read_chk("basic_status", 4'h0, 32'h2);

      // clipping at the bottom-right corner
      obs.delete();
      reg_wr(4'h4, 32'hEFEE); reg_wr(4'h8, 32'h0505); reg_wr(4'h0, 32'd1);
      wait_idle(100);
      chk("clip_count", obs.size(), 2);
      if (obs.size() >= 2) begin
         chk("clip_addr0", 32'(obs[0].a), 32'hEFEE);
         chk("clip_addr1", 32'(obs[1].a), 32'hEFEF);
      end

      // CPU store in the third fill slot
      obs.delete();
      reg_wr(4'h4, 32'h0A10); reg_wr(4'h8, 32'h0104); reg_wr(4'hC, 32'd3);
      reg_wr(4'h0, 32'd1);
      @(negedge clk);
      @(negedge clk);
      pix_we_i = 1; pix_addr_i = 16'h1234; pix_wdata_i = 3'd2;
      @(negedge clk);
      pix_we_i = 0;
      wait_idle(100);
      chk("arb_count", obs.size(), 5);
      for (int i = 0; i < 5 && i < obs.size(); i++) begin
         chk("arb_addr", 32'(obs[i].a), 32'(arb_a[i]));
         chk("arb_data", 32'(obs[i].d), 32'(arb_d[i]));
      end

      // abort after three writes, then restart
      obs.delete();
      reg_wr(4'h4, 32'h0000); reg_wr(4'h8, 32'h0A0A); reg_wr(4'hC, 32'd7);
      reg_wr(4'h0, 32'd1);
      wait_obs(3, 50);
      reg_we_i = 1; reg_addr_i = 4'h0; reg_wdata_i = 32'd2;
      @(negedge clk);
      reg_we_i = 0;
      repeat (6) @(negedge clk);
      chk("abort_count", obs.size(), 3);
      chk("abort_busy", 32'(busy_o), 32'd0);
      read_chk("abort_status", 4'h0, 32'h0);
      obs.delete();
      reg_wr(4'h0, 32'd1);
      wait_idle(300);
      chk("restart_count", obs.size(), 100);
      if (obs.size() == 100) begin
         chk("restart_first", 32'(obs[0].a), 32'h0000);
         chk("restart_last", 32'(obs[99].a), 32'h0909);
      end

      // START and ABORT together
      obs.delete(); busy_cnt = 0;
      reg_wr(4'h0, 32'd3);
      repeat (5) @(negedge clk);
      chk("startabort_count", obs.size(), 0);
      chk("startabort_busy", busy_cnt, 0);

      // zero-size start after an abort leaves done=0 first
      reg_wr(4'h0, 32'd1);
      reg_wr(4'h0, 32'd2);
      wait_idle(50);
      obs.delete(); busy_cnt = 0;
      reg_wr(4'h4, 32'h00F0); reg_wr(4'h0, 32'd1);
      wait_idle(50);
      chk("zero_count", obs.size(), 0);
      chk("zero_busy", busy_cnt, 0);
      read_chk("zero_status", 4'h0, 32'h2);

      // shadowing of ORIGIN/COLOR during a fill
      obs.delete();
      reg_wr(4'h4, 32'h0101); reg_wr(4'h8, 32'h0303); reg_wr(4'hC, 32'd1);
      reg_wr(4'h0, 32'd1);
      reg_wr(4'h4, 32'h2020); reg_wr(4'hC, 32'd6);
      wait_idle(100);
      chk("shadow_count", obs.size(), 9);
      if (obs.size() == 9) begin
         chk("shadow_first", 32'(obs[0].a), 32'h0101);
         chk("shadow_last", 32'(obs[8].a), 32'h0303);
         chk("shadow_color", 32'(obs[4].d), 32'd1);
      end
      read_chk("origin_rd", 4'h4, 32'h2020);
      obs.delete();
      reg_wr(4'h0, 32'd1);
      wait_idle(100);
      chk("next_count", obs.size(), 9);
      if (obs.size() == 9) begin
         chk("next_first", 32'(obs[0].a), 32'h2020);
         chk("next_color", 32'(obs[0].d), 32'd6);
         chk("next_last", 32'(obs[8].a), 32'h2222);
      end

      // randomized fills with CPU stores and stray register traffic
      for (int it = 0; it < 40; it++) begin
         logic [7:0] rx, ry;
         rx = ($urandom % 2) ? 8'($urandom_range(200, 255))
                             : 8'($urandom_range(0, 60));
         ry = ($urandom % 2) ? 8'($urandom_range(220, 255))
                             : 8'($urandom_range(0, 60));
         reg_wr(4'h4, {16'b0, ry, rx});
         reg_wr(4'h8, {16'b0, 8'($urandom_range(0, 8)),
                       8'($urandom_range(0, 20))});
         reg_wr(4'hC, 32'($urandom % 8));
         reg_wr(4'h0, 32'd1);
         for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!busy_o) break;
            pix_we_i    = ($urandom % 4) == 0;
            pix_addr_i  = 16'($urandom);
            pix_wdata_i = 3'($urandom);
            reg_we_i    = ($urandom % 48) == 0;
            reg_addr_i  = 4'($urandom);
            reg_wdata_i = 32'($urandom % 65536);
         end
         pix_we_i = 0; reg_we_i = 0;
         wait_idle(50);
      end

      // reset in mid-fill
      reg_wr(4'h4, 32'h0505); reg_wr(4'h8, 32'h0A0A); reg_wr(4'hC, 32'd4);
      reg_wr(4'h0, 32'd1);
      repeat (10) @(negedge clk);
      rst_i = 1;
      @(negedge clk);
      rst_i = 0;
      chk("midrst_we", 32'(vmem_we_o), 32'd0);
      chk("midrst_busy", 32'(busy_o), 32'd0);
      read_chk("midrst_ctrl", 4'h0, 32'd0);
      read_chk("midrst_origin", 4'h4, 32'd0);
      read_chk("midrst_size", 4'h8, 32'd0);
      read_chk("midrst_color", 4'hC, 32'd0);
      repeat (5) @(negedge clk);

      chk("exp_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
